// File: rtl/snow64_lar_element_sequencer.sv
// -----------------------------------------------------------------------------
// snow64_lar_element_sequencer
//
// Walks a 256-bit LAR line one scalar element at a time and presents each
// element, extended to 64 bits, on a valid/ready output stream. One line is
// held at a time. A new line can be accepted on the same cycle that the last
// element of the current line is consumed, so the output stays continuous.
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   flush             synchronous abort of the current line (wins over all)
//   in_valid/in_ready line handshake (in_ready is combinational)
//   in_data           LAR line to iterate
//   in_data_type      0 uint, 1 sint, 2 BFloat16, 3 reserved (acts as uint)
//   in_int_type_size  0/1/2/3 = 8/16/32/64-bit integer elements
//   in_data_offset    starting byte offset (used only with the macro below)
//   out_valid/out_ready element handshake
//   out_data          extracted element, sign- or zero-extended to 64 bits
//   out_data_offset   byte offset of out_data within the line
//   out_last          out_data is the final element of the line
//
// Configuration
//   SNOW64_LAR_ELEMENT_SEQUENCER_START_OFFSET_EN
//     defined   : iteration starts at in_data_offset rounded down to the
//                 element alignment
//     undefined : iteration always starts at byte 0; in_data_offset ignored
// -----------------------------------------------------------------------------
module snow64_lar_element_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  input  logic [1:0]   in_data_type,
  input  logic [1:0]   in_int_type_size,
  input  logic [4:0]   in_data_offset,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic [4:0]   out_data_offset,
  output logic         out_last
);

  localparam int unsigned LAR_DATA_W = 256;
  localparam int unsigned SCALAR_W   = 64;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned TYPE_W     = 2;
  localparam int unsigned SIZE_W     = 2;
  localparam int unsigned BYTES_W    = 4;

  localparam logic [TYPE_W-1:0] TYPE_SINT = 2'd1;
  localparam logic [TYPE_W-1:0] TYPE_BF16 = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Element width in bytes: BFloat16 is always 2, everything else by size.
  function automatic logic [BYTES_W-1:0] elem_bytes(
    input logic [TYPE_W-1:0] dtype,
    input logic [SIZE_W-1:0] isz
  );
    logic [BYTES_W-1:0] b;
    if (dtype == TYPE_BF16) begin
      b = 4'd2;
    end else begin
      case (isz)
        2'd0:    b = 4'd1;
        2'd1:    b = 4'd2;
        2'd2:    b = 4'd4;
        default: b = 4'd8;
      endcase
    end
    return b;
  endfunction

  // Little-endian element at byte offset off, extended to 64 bits.
  function automatic logic [SCALAR_W-1:0] extract(
    input logic [LAR_DATA_W-1:0] line,
    input logic [OFFSET_W-1:0]   off,
    input logic [TYPE_W-1:0]     dtype,
    input logic [SIZE_W-1:0]     isz
  );
    logic [SCALAR_W-1:0] raw;
    logic                sgn;
    logic [SCALAR_W-1:0] res;
    raw = SCALAR_W'(line >> {off, 3'b000});
    sgn = (dtype == TYPE_SINT);
    if (dtype == TYPE_BF16) begin
      res = {48'b0, raw[15:0]};
    end else begin
      case (isz)
        2'd0:    res = sgn ? {{56{raw[7]}},  raw[7:0]}  : {56'b0, raw[7:0]};
        2'd1:    res = sgn ? {{48{raw[15]}}, raw[15:0]} : {48'b0, raw[15:0]};
        2'd2:    res = sgn ? {{32{raw[31]}}, raw[31:0]} : {32'b0, raw[31:0]};
        default: res = raw;
      endcase
    end
    return res;
  endfunction

  // An element is last when it ends exactly at the line boundary.
  function automatic logic ends_line(
    input logic [OFFSET_W-1:0] off,
    input logic [BYTES_W-1:0]  bytes
  );
    return ((6'(off) + 6'(bytes)) == 6'd32);
  endfunction

  // State and datapath registers.
  state_t                  state_q, state_d;
  logic                    ready_en_q;
  logic [LAR_DATA_W-1:0]   line_q, line_d;
  logic [TYPE_W-1:0]       type_q, type_d;
  logic [SIZE_W-1:0]       isize_q, isize_d;
  logic                    out_valid_d;
  logic [SCALAR_W-1:0]     out_data_d;
  logic [OFFSET_W-1:0]     out_data_offset_d;
  logic                    out_last_d;

  logic [BYTES_W-1:0]      in_bytes;
  logic [BYTES_W-1:0]      cur_bytes;
  logic [OFFSET_W-1:0]     start_off;
  logic [OFFSET_W-1:0]     next_off;
  logic                    accept;
  logic                    advance;

  assign in_bytes  = elem_bytes(in_data_type, in_int_type_size);
  assign cur_bytes = elem_bytes(type_q, isize_q);
  assign next_off  = out_data_offset + OFFSET_W'(cur_bytes);

`ifdef SNOW64_LAR_ELEMENT_SEQUENCER_START_OFFSET_EN
  // Round the requested start down to a multiple of the element size.
  assign start_off = in_data_offset & ~(OFFSET_W'(in_bytes) - 5'd1);
`else
  logic unused_in_data_offset;
  assign unused_in_data_offset = ^in_data_offset;
  assign start_off = '0;
`endif

  // Ready when idle, or when the current line's last element leaves this
  // cycle; held low through reset until the first clock after release.
  assign in_ready = ready_en_q && !flush &&
                    ((state_q == ST_IDLE) || (out_valid && out_ready && out_last));

  assign accept  = in_valid && in_ready;
  assign advance = out_valid && out_ready;

  // Next-state and output logic.
  always_comb begin
    state_d           = state_q;
    line_d            = line_q;
    type_d            = type_q;
    isize_d           = isize_q;
    out_valid_d       = out_valid;
    out_data_d        = out_data;
    out_data_offset_d = out_data_offset;
    out_last_d        = out_last;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d           = ST_RUN;
          line_d            = in_data;
          type_d            = in_data_type;
          isize_d           = in_int_type_size;
          out_valid_d       = 1'b1;
          out_data_d        = extract(in_data, start_off, in_data_type, in_int_type_size);
          out_data_offset_d = start_off;
          out_last_d        = ends_line(start_off, in_bytes);
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (out_last) begin
            if (accept) begin
              // Back-to-back line: reload without dropping out_valid.
              line_d            = in_data;
              type_d            = in_data_type;
              isize_d           = in_int_type_size;
              out_data_d        = extract(in_data, start_off, in_data_type, in_int_type_size);
              out_data_offset_d = start_off;
              out_last_d        = ends_line(start_off, in_bytes);
            end else begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end
          end else begin
            out_data_d        = extract(line_q, next_off, type_q, isize_q);
            out_data_offset_d = next_off;
            out_last_d        = ends_line(next_off, cur_bytes);
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    // Abort overrides any handshake or acceptance in the same cycle.
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      ready_en_q      <= 1'b0;
      line_q          <= '0;
      type_q          <= '0;
      isize_q         <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_data_offset <= '0;
      out_last        <= 1'b0;
    end else begin
      state_q         <= state_d;
      ready_en_q      <= 1'b1;
      line_q          <= line_d;
      type_q          <= type_d;
      isize_q         <= isize_d;
      out_valid       <= out_valid_d;
      out_data        <= out_data_d;
      out_data_offset <= out_data_offset_d;
      out_last        <= out_last_d;
    end
  end

endmodule

// File: tb/tb_snow64_lar_element_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snow64_lar_element_sequencer
//
// Self-checking bench. Each accepted line pushes its expected element sequence
// into a scoreboard; a monitor pops and compares on every output handshake and
// checks that stalled outputs hold. Scenario tasks add their own checks.
// -----------------------------------------------------------------------------
module tb_snow64_lar_element_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic [1:0]   in_data_type;
  logic [1:0]   in_int_type_size;
  logic [4:0]   in_data_offset;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [4:0]   out_data_offset;
  logic         out_last;

  snow64_lar_element_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_data_type     (in_data_type),
    .in_int_type_size (in_int_type_size),
    .in_data_offset   (in_data_offset),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_data_offset  (out_data_offset),
    .out_last         (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  o;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   popped      = 0;
  int   stall_checks = 0;
  int   last_off_seen = -1;

  logic        stalled = 1'b0;
  logic [63:0] held_d;
  logic [4:0]  held_o;
  logic        held_l;

  // Reference model: byte-wise walk of the line from the start offset.
  function automatic void push_line(input logic [255:0] line, input logic [1:0] t,
                                    input logic [1:0] sz, input logic [4:0] off);
    int          eb;
    int          start;
    logic [63:0] v;
    exp_t        e;
    eb = (t == 2'd2) ? 2 : (1 << sz);
    start = int'(off) & ~(eb - 1);
`ifndef SNOW64_LAR_ELEMENT_SEQUENCER_START_OFFSET_EN
    start = 0;
`endif
    for (int o = start; o < 32; o += eb) begin
      v = '0;
      for (int b = 0; b < eb; b++) v[b*8 +: 8] = line[(o+b)*8 +: 8];
      if (t == 2'd1 && eb < 8 && v[eb*8-1])
        for (int b = eb; b < 8; b++) v[b*8 +: 8] = 8'hFF;
      e.d = v;
      e.o = 5'(o);
      e.l = (o + eb == 32);
      sb.push_back(e);
    end
  endfunction

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) begin
        vectors++;
        stall_checks++;
        if ({out_data, out_data_offset, out_last} !== {held_d, held_o, held_l}) begin
          miscompares++;
          $display("FAIL stall_hold: got data=%h off=%0d last=%b, held data=%h off=%0d last=%b",
                   out_data, out_data_offset, out_last, held_d, held_o, held_l);
        end
      end
      stalled = out_valid && !out_ready && !flush;
      held_d  = out_data;
      held_o  = out_data_offset;
      held_l  = out_last;
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL element: unexpected element data=%h off=%0d, scoreboard empty",
                     out_data, out_data_offset);
          end else begin
            e = sb.pop_front();
            popped++;
            if (out_last) last_off_seen = int'(out_data_offset);
            if ({out_data, out_data_offset, out_last} !== {e.d, e.o, e.l}) begin
              miscompares++;
              $display("FAIL element: got data=%h off=%0d last=%b, expected data=%h off=%0d last=%b",
                       out_data, out_data_offset, out_last, e.d, e.o, e.l);
            end
          end
        end
        if (in_valid && in_ready)
          push_line(in_data, in_data_type, in_int_type_size, in_data_offset);
      end
    end
  end

  // Offer a line and return just after the accepting edge (in_valid left high).
  task automatic offer(input logic [255:0] d, input logic [1:0] t,
                       input logic [1:0] sz, input logic [4:0] off);
    bit ok;
    ok = 0;
    in_data          = d;
    in_data_type     = t;
    in_int_type_size = sz;
    in_data_offset   = off;
    in_valid         = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL offer_timeout: line not accepted within 100 cycles, required acceptance");
    end
  endtask

  // Wait until the DUT is idle with nothing left to deliver.
  task automatic drain(output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!out_valid && sb.size() == 0) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_data_type = '0; in_int_type_size = '0; in_data_offset = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_last} !== 3'b000 || out_data !== 64'd0 || out_data_offset !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b valid=%b last=%b data=%h off=%0d, required all zero",
               in_ready, out_valid, out_last, out_data, out_data_offset);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_clock: in_ready=%b, required 0", in_ready);
    end
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_dword_stream();
    int p0; bit to;
    @(posedge clk); #1;
    out_ready = 1'b1;
    p0 = popped;
    offer(rand_line(), 2'd0, 2'd3, 5'd0);
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_latency: out_valid=%b one cycle after accept, required 1", out_valid);
    end
    drain(to);
    vectors++;
    if (to || popped - p0 != 4 || last_off_seen != 24 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL dword_stream: timeout=%0d elems=%0d last_off=%0d ready=%b, required 0/4/24/1",
               to, popped - p0, last_off_seen, in_ready);
    end
  endtask

  task automatic test_signed_bytes();
    logic [255:0] d; int p0; bit to; bit found;
    @(posedge clk); #1;
    out_ready = 1'b1;
    d = rand_line();
    d[47:40] = 8'h80;
    p0 = popped;
    found = 0;
    offer(d, 2'd1, 2'd0, 5'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_data_offset == 5'd5) begin
        found = 1;
        vectors++;
        if (out_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
          miscompares++;
          $display("FAIL sign_extend: got %h, required ffffffffffffff80", out_data);
        end
      end
    end
    drain(to);
    vectors++;
    if (!found || to || popped - p0 != 32) begin
      miscompares++;
      $display("FAIL signed_bytes: found=%0d timeout=%0d elems=%0d, required 1/0/32",
               found, to, popped - p0);
    end
  endtask

  task automatic test_bf16_stall();
    int p0, s0; bit done;
    @(posedge clk); #1;
    out_ready = 1'b1;
    p0 = popped;
    s0 = stall_checks;
    done = 0;
    offer(rand_line(), 2'd2, 2'd3, 5'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!out_valid && sb.size() == 0) done = 1;
      else begin
        @(posedge clk); #1;
        out_ready = ~out_ready;
      end
    end
    out_ready = 1'b1;
    vectors++;
    if (!done || popped - p0 != 16 || stall_checks - s0 < 8 || last_off_seen != 30) begin
      miscompares++;
      $display("FAIL bf16_stall: done=%0d elems=%0d stalls=%0d last_off=%0d, required 1/16/>=8/30",
               done, popped - p0, stall_checks - s0, last_off_seen);
    end
  endtask

  task automatic test_back_to_back();
    int p0, run; bit to;
    @(posedge clk); #1;
    out_ready = 1'b1;
    p0 = popped;
    run = 0;
    offer(rand_line(), 2'd0, 2'd3, 5'd0);
    fork
      begin
        offer(rand_line(), 2'd1, 2'd2, 5'd0);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (out_valid) run++;
          else break;
        end
      end
    join
    drain(to);
    vectors++;
    if (to || run != 12 || popped - p0 != 12) begin
      miscompares++;
      $display("FAIL back_to_back: timeout=%0d valid_run=%0d elems=%0d, required 0/12/12",
               to, run, popped - p0);
    end
  endtask

  task automatic test_flush();
    bit seen; int q0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    seen = 0;
    offer(rand_line(), 2'd0, 2'd3, 5'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_data_offset == 5'd8) seen = 1;
    end
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = rand_line();
    @(negedge clk);
    vectors++;
    if (!seen || in_ready !== 1'b0 || out_data_offset !== 5'd16) begin
      miscompares++;
      $display("FAIL flush_cycle: seen2nd=%0d ready=%b off=%0d, required 1/0/16",
               seen, in_ready, out_data_offset);
    end
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    q0 = sb.size();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q0 != 0) begin
      miscompares++;
      $display("FAIL flush_after: valid=%b ready=%b pending=%0d, required 0/1/0",
               out_valid, in_ready, q0);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL flush_idle: out_valid=1 after flush, required 0");
    end
  endtask

  task automatic test_start_offset();
    int p0, exp_n; logic [4:0] exp_first; bit to; logic [4:0] first;
`ifdef SNOW64_LAR_ELEMENT_SEQUENCER_START_OFFSET_EN
    exp_first = 5'd12; exp_n = 5;
`else
    exp_first = 5'd0;  exp_n = 8;
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    p0 = popped;
    offer(rand_line(), 2'd0, 2'd2, 5'd13);
    in_valid = 1'b0;
    @(negedge clk);
    first = out_data_offset;
    vectors++;
    if (out_valid !== 1'b1 || first !== exp_first) begin
      miscompares++;
      $display("FAIL start_offset: valid=%b first_off=%0d, required 1/%0d", out_valid, first, exp_first);
    end
    drain(to);
    vectors++;
    if (to || popped - p0 != exp_n || last_off_seen != 28) begin
      miscompares++;
      $display("FAIL offset_walk: timeout=%0d elems=%0d last_off=%0d, required 0/%0d/28",
               to, popped - p0, last_off_seen, exp_n);
    end
  endtask

  task automatic test_reset_mid_line();
    bit seen;
    @(posedge clk); #1;
    out_ready = 1'b0;
    offer(rand_line(), 2'd0, 2'd0, 5'd0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_line_active: out_valid=%b before reset, required 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b ready=%b, required 0/0", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    vectors++;
    if (seen || sb.size() != 0) begin
      miscompares++;
      $display("FAIL reset_discard: out_valid seen=%0d pending=%0d, required 0/0", seen, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_dword_stream();
    test_signed_bytes();
    test_bf16_stall();
    test_back_to_back();
    test_flush();
    test_start_offset();
    test_reset_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
